ram_pack_sched: RTL and testbench
=================================

Name: ram_pack_sched

Overview:
Sequencer that copies a programmable run of bytes from an async-read byte RAM (8-bit, 32 deep) into a word RAM (16-bit, 16 deep).
- Each word is built from two consecutive bytes.
- Host interface: start/abort, busy/done/aborted status.
- Drives the byte-RAM read port and the word-RAM write port directly.
- Replaces hard-wired IDLE/READ/WRITE control: base addresses, length and byte order are configurable per job.

Parameters:
DATA_W, 8, byte width; word width is 2*DATA_W
SRC_AW, 5, byte-RAM address width
DST_AW, 4, word-RAM address width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  job request; sampled only in IDLE
abort  in  1  terminate current job
src_base  in  SRC_AW  first byte address; latched at start
dst_base  in  DST_AW  first word address; latched at start
word_cnt  in  DST_AW+1  words to copy; latched at start
swap  in  1  byte order; latched at start
src_rd_addr  out  SRC_AW  byte-RAM read address
src_rd_data  in  DATA_W  byte-RAM async read data
dst_we  out  1  word-RAM write enable
dst_wr_addr  out  DST_AW  word-RAM write address
dst_wr_data  out  2*DATA_W  word-RAM write data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in FINISH
aborted  out  1  set when a job ends by abort; cleared at next accepted start
words_done  out  DST_AW+1  words written in current/last job

Behaviour:
- Reset (sync, high) at any time, including mid-job:
  - next state IDLE; all pointers, byte registers, words_done and aborted cleared.
  - dst_we=0, done=0, src_rd_addr=0, dst_wr_addr=0, dst_wr_data=0.
  - no write is issued and no done pulse follows.
- States: IDLE, RD_LO, RD_HI, WR, FINISH. Moore outputs; dst_we=1 only in WR.
- IDLE:
  - start=1 latches src_ptr=src_base, dst_ptr=dst_base, swap.
  - rem=min(word_cnt, 2^DST_AW); word_cnt >16 is clamped to 16.
  - clears words_done and aborted.
  - next state RD_LO, or FINISH if rem==0.
- RD_LO: src_rd_addr=src_ptr; lo<=src_rd_data; src_ptr++; -> RD_HI.
- RD_HI: src_rd_addr=src_ptr; hi<=src_rd_data; src_ptr++; -> WR.
- WR:
  - dst_we=1, dst_wr_addr=dst_ptr.
  - dst_wr_data = swap ? {lo,hi} : {hi,lo}.
  - dst_ptr++, words_done++, rem--.
  - next state FINISH if rem==1, else RD_LO.
- FINISH: done=1 for exactly one cycle; busy=1; -> IDLE.
- Latency:
  - start sampled at edge E0 -> word k (0-based) is written in cycle 3k+3 after E0.
  - done in cycle 3N+1 after E0, where N=rem.
  - rem==0 -> done in cycle 1.
- Pointer wrap: src_ptr and dst_ptr wrap modulo 2^SRC_AW / 2^DST_AW with no error.
- start while busy is ignored; no queuing.
- Abort:
  - abort=1 in RD_LO/RD_HI/WR -> next state FINISH, aborted<=1.
  - abort in WR suppresses dst_we that cycle; words_done is not incremented.
  - abort in IDLE or FINISH has no effect.
- Reset has priority over abort; abort has priority over normal transitions.
- words_done holds its final value after the job until the next accepted start.

Test Plan:
- Byte RAM[i]=i, start src_base=0, dst_base=0, cnt=16, swap=0:
  - 16 writes; word k = {2k+1, 2k}, e.g. addr0=0x0100, addr15=0x1F1E.
  - done in cycle 49 after start edge; words_done=16; aborted=0.
- src_base=4, dst_base=10, cnt=2, swap=1:
  - addr10=0x0405, addr11=0x0607; no other dst_we; done at cycle 7.
- Wrap: src_base=30, dst_base=15, cnt=2, swap=0:
  - reads 30,31,0,1; writes addr15=0x1F1E then addr0=0x0100.
- cnt=0:
  - busy high one cycle, done pulse in cycle 1, dst_we never high.
- cnt=5, abort high for one cycle during RD_HI of word 2:
  - exactly 2 writes (addr0, addr1); done pulse follows; aborted=1; words_done=2.
  - next start clears aborted.
- cnt=16, reset asserted in cycle 20:
  - IDLE next edge; all outputs 0; no done pulse.
- Separately, start pulsed while busy:
  - ignored; the job completes unchanged.

Source files
------------

// File: rtl/ram_pack_sched_if.sv
// Memory-side bus of the pack sequencer: byte-RAM async read port and
// word-RAM write port. The sequencer is the master; the RAMs sit on slave.
interface ram_pack_sched_if #(
  parameter int DATA_W = 8,
  parameter int SRC_AW = 5,
  parameter int DST_AW = 4
);
  logic [SRC_AW-1:0]   src_rd_addr;
  logic [DATA_W-1:0]   src_rd_data;
  logic                dst_we;
  logic [DST_AW-1:0]   dst_wr_addr;
  logic [2*DATA_W-1:0] dst_wr_data;

  modport master (
    output src_rd_addr,
    input  src_rd_data,
    output dst_we,
    output dst_wr_addr,
    output dst_wr_data
  );

  modport slave (
    input  src_rd_addr,
    output src_rd_data,
    input  dst_we,
    input  dst_wr_addr,
    input  dst_wr_data
  );
endinterface

// File: rtl/ram_pack_sched.sv
// Byte-to-word pack sequencer: copies word_cnt pairs of bytes from an
// async-read byte RAM into a word RAM, with per-job base addresses,
// length and byte order.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start; job parameters latched on start
// RD_LO  | read low byte at src_ptr
// RD_HI  | read high byte at src_ptr
// WR     | write packed word at dst_ptr (suppressed by abort)
// FINISH | one-cycle done pulse, then back to IDLE
module ram_pack_sched #(
  parameter int DATA_W = 8,
  parameter int SRC_AW = 5,
  parameter int DST_AW = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [SRC_AW-1:0]      src_base,
  input  logic [DST_AW-1:0]      dst_base,
  input  logic [DST_AW:0]        word_cnt,
  input  logic                   swap,
  ram_pack_sched_if.master       mem,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [DST_AW:0]        words_done
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, FINISH} state_t;

  localparam logic [DST_AW:0] MAX_WORDS = (DST_AW+1)'(1) << DST_AW;

  state_t              state_q, state_d;
  logic [SRC_AW-1:0]   src_ptr;
  logic [DST_AW-1:0]   dst_ptr;
  logic [DST_AW:0]     rem;
  logic [DATA_W-1:0]   lo, hi;
  logic                swap_q;
  logic [DST_AW:0]     cnt_clamped;

  // Lengths beyond the word-RAM depth would only overwrite earlier words.
  assign cnt_clamped = (word_cnt > MAX_WORDS) ? MAX_WORDS : word_cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort outranks the normal sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (cnt_clamped == '0) ? FINISH : RD_LO;
      RD_LO:  state_d = abort ? FINISH : RD_HI;
      RD_HI:  state_d = abort ? FINISH : WR;
      WR:     state_d = (abort || rem == (DST_AW+1)'(1)) ? FINISH : RD_LO;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: job latch, byte capture, pointers and remaining-word down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      rem        <= '0;
      lo         <= '0;
      hi         <= '0;
      swap_q     <= 1'b0;
      words_done <= '0;
      aborted    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          src_ptr    <= src_base;
          dst_ptr    <= dst_base;
          rem        <= cnt_clamped;
          swap_q     <= swap;
          words_done <= '0;
          aborted    <= 1'b0;
        end
        RD_LO: if (abort) aborted <= 1'b1;
        else begin
          lo      <= mem.src_rd_data;
          src_ptr <= src_ptr + SRC_AW'(1);
        end
        RD_HI: if (abort) aborted <= 1'b1;
        else begin
          hi      <= mem.src_rd_data;
          src_ptr <= src_ptr + SRC_AW'(1);
        end
        WR: if (abort) aborted <= 1'b1;
        else begin
          dst_ptr    <= dst_ptr + DST_AW'(1);
          words_done <= words_done + (DST_AW+1)'(1);
          rem        <= rem - (DST_AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs; the only input-dependent term is abort masking the write.
  always_comb begin
    mem.src_rd_addr = src_ptr;
    mem.dst_wr_addr = dst_ptr;
    mem.dst_wr_data = swap_q ? {lo, hi} : {hi, lo};
    mem.dst_we      = (state_q == WR) && !abort;
    busy            = (state_q != IDLE);
    done            = (state_q == FINISH);
  end

endmodule

// File: tb/tb_ram_pack_sched.sv
// Bench for ram_pack_sched: byte RAM modelled as an array, expected writes
// (address, data, cycle) queued at job start and compared to observed writes.
module tb_ram_pack_sched;
  logic       clk = 1'b0;
  logic       reset, start, abort, swap;
  logic [4:0] src_base;
  logic [3:0] dst_base;
  logic [4:0] word_cnt;
  logic       busy, done, aborted;
  logic [4:0] words_done;
  logic [7:0] byte_ram [32];

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [7:0]  cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  errors = 0;
  int  checks = 0;
  int  done_cyc, done_cnt, busy_cnt;

  ram_pack_sched_if ram_if ();
  assign ram_if.src_rd_data = byte_ram[ram_if.src_rd_addr];

  always #5 clk = ~clk;

  ram_pack_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .word_cnt   (word_cnt),
    .swap       (swap),
    .mem        (ram_if.master),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .words_done (words_done)
  );

  task automatic push_expected(input int sb, input int db, input int n, input logic sw);
    for (int k = 0; k < n; k++) begin
      wr_t e;
      logic [7:0] lo, hi;
      lo = byte_ram[(sb + 2*k) % 32];
      hi = byte_ram[(sb + 2*k + 1) % 32];
      e.addr = 4'((db + k) % 16);
      e.data = sw ? {lo, hi} : {hi, lo};
      e.cyc  = 8'(3*k + 3);
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_start(input int sb, input int db, input int wc, input logic sw);
    @(negedge clk);
    src_base = 5'(sb);
    dst_base = 4'(db);
    word_cnt = 5'(wc);
    swap     = sw;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Records writes, done pulses and busy cycles; cycle 1 is the one after the start edge.
  task automatic collect(input int ncyc, input int abort_c, input int reset_c, input int start_c);
    wr_t o;
    obs_q.delete();
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      abort = (c == abort_c);
      reset = (c == reset_c);
      start = (c == start_c);
      #1;
      if (ram_if.dst_we) begin
        o = {ram_if.dst_wr_addr, ram_if.dst_wr_data, 8'(c)};
        obs_q.push_back(o);
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (busy) busy_cnt++;
    end
    abort = 1'b0;
    reset = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ram_if.dst_we} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got busy/done/we=%b exp 000", {busy, done, ram_if.dst_we});
    end
    checks++;
    if ({ram_if.src_rd_addr, ram_if.dst_wr_addr, ram_if.dst_wr_data} !== 25'd0) begin
      errors++; $display("FAIL reset_bus got src=%0h dst=%0h data=%0h exp 0",
                         ram_if.src_rd_addr, ram_if.dst_wr_addr, ram_if.dst_wr_data);
    end
    checks++;
    if ({aborted, words_done} !== 6'd0) begin
      errors++; $display("FAIL reset_status got aborted=%b words_done=%0d exp 0", aborted, words_done);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_full(input string name, input int wc);
    wr_t e, o;
    drive_start(0, 0, wc, 1'b0);
    push_expected(0, 0, 16, 1'b0);
    collect(55, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s_wr missing write exp %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL %s_wr got %h exp %h", name, o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra got %0d extra writes exp 0", name, obs_q.size()); end
    checks++;
    if (done_cyc != 49 || done_cnt != 1) begin
      errors++; $display("FAIL %s_done got cycle %0d count %0d exp 49/1", name, done_cyc, done_cnt);
    end
    checks++;
    if (busy_cnt != 49) begin errors++; $display("FAIL %s_busy got %0d exp 49", name, busy_cnt); end
    checks++;
    if (words_done !== 5'd16 || aborted !== 1'b0) begin
      errors++; $display("FAIL %s_status got words_done=%0d aborted=%b exp 16/0", name, words_done, aborted);
    end
  endtask

  task automatic test_small(input string name, input int sb, input int db, input logic sw);
    wr_t e, o;
    drive_start(sb, db, 2, sw);
    push_expected(sb, db, 2, sw);
    collect(12, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s_wr missing write exp %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL %s_wr got %h exp %h", name, o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra got %0d extra writes exp 0", name, obs_q.size()); end
    checks++;
    if (done_cyc != 7 || done_cnt != 1) begin
      errors++; $display("FAIL %s_done got cycle %0d count %0d exp 7/1", name, done_cyc, done_cnt);
    end
  endtask

  task automatic test_zero();
    drive_start(3, 3, 0, 1'b0);
    collect(6, 0, 0, 0);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL zero_wr got %0d writes exp 0", obs_q.size()); end
    checks++;
    if (done_cyc != 1 || done_cnt != 1 || busy_cnt != 1) begin
      errors++; $display("FAIL zero_timing got done %0d/%0d busy %0d exp 1/1 busy 1", done_cyc, done_cnt, busy_cnt);
    end
    checks++;
    if (words_done !== 5'd0) begin errors++; $display("FAIL zero_words got %0d exp 0", words_done); end
  endtask

  task automatic test_abort();
    wr_t e, o;
    drive_start(0, 0, 5, 1'b0);
    push_expected(0, 0, 2, 1'b0);
    collect(25, 8, 0, 0);   // cycle 8 is RD_HI of word 2
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL abort_wr missing write exp %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL abort_wr got %h exp %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL abort_extra got %0d extra writes exp 0", obs_q.size()); end
    checks++;
    if (done_cyc != 9 || done_cnt != 1) begin
      errors++; $display("FAIL abort_done got cycle %0d count %0d exp 9/1", done_cyc, done_cnt);
    end
    checks++;
    if (aborted !== 1'b1 || words_done !== 5'd2) begin
      errors++; $display("FAIL abort_status got aborted=%b words_done=%0d exp 1/2", aborted, words_done);
    end
    drive_start(0, 0, 1, 1'b0);
    checks++;
    if (aborted !== 1'b0 || words_done !== 5'd0) begin
      errors++; $display("FAIL abort_clear got aborted=%b words_done=%0d exp 0/0", aborted, words_done);
    end
    collect(8, 0, 0, 0);
    checks++;
    if (done_cyc != 4 || aborted !== 1'b0 || words_done !== 5'd1) begin
      errors++; $display("FAIL abort_next got done %0d aborted=%b words=%0d exp 4/0/1", done_cyc, aborted, words_done);
    end
  endtask

  task automatic test_reset_mid();
    wr_t e, o;
    drive_start(0, 0, 16, 1'b0);
    push_expected(0, 0, 6, 1'b0);
    collect(30, 0, 20, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rstmid_wr missing write exp %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL rstmid_wr got %h exp %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL rstmid_after got %0d extra writes %0d done exp 0/0", obs_q.size(), done_cnt);
    end
    checks++;
    if ({busy, done, ram_if.dst_we, aborted, words_done} !== 9'd0 ||
        {ram_if.src_rd_addr, ram_if.dst_wr_addr, ram_if.dst_wr_data} !== 25'd0) begin
      errors++; $display("FAIL rstmid_outputs got busy=%b we=%b src=%0h dst=%0h data=%0h words=%0d exp all 0",
                         busy, ram_if.dst_we, ram_if.src_rd_addr, ram_if.dst_wr_addr, ram_if.dst_wr_data, words_done);
    end
  endtask

  task automatic test_start_busy();
    wr_t e, o;
    drive_start(2, 3, 3, 1'b0);
    push_expected(2, 3, 3, 1'b0);
    src_base = 5'd20;
    dst_base = 4'd9;
    word_cnt = 5'd7;
    swap     = 1'b1;
    collect(20, 0, 0, 4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL busystart_wr missing write exp %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL busystart_wr got %h exp %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL busystart_extra got %0d extra writes exp 0", obs_q.size()); end
    checks++;
    if (done_cyc != 10 || done_cnt != 1 || busy_cnt != 10 || words_done !== 5'd3) begin
      errors++; $display("FAIL busystart_timing got done %0d/%0d busy %0d words %0d exp 10/1/10/3",
                         done_cyc, done_cnt, busy_cnt, words_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) byte_ram[i] = 8'(i);
    reset = 1'b0; start = 1'b0; abort = 1'b0; swap = 1'b0;
    src_base = '0; dst_base = '0; word_cnt = '0;
    test_reset();
    test_full("full", 16);
    test_full("clamp", 31);
    test_small("swap", 4, 10, 1'b1);
    test_small("wrap", 30, 15, 1'b0);
    test_zero();
    test_abort();
    test_reset_mid();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion exp finish within bound");
    $fatal(1, "timeout");
  end
endmodule
